// File: rtl/pixel_fetch.sv
// Pixel-domain FIFO read front end: fill gating, frame alignment, underrun/misalignment
// recovery. Optional underrun statistics counter enabled by PIXEL_FETCH_STATS_EN.
module pixel_fetch #(
  parameter int unsigned HDISP   = 800,
  parameter int unsigned VDISP   = 480,
  parameter logic [23:0] ERR_RGB = 24'hFF00FF
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        frame_start,
  input  logic        pix_req,
  input  logic [23:0] fifo_rdata,
  input  logic        fifo_empty,
  input  logic        fifo_almost_full,
  output logic        fifo_rdreq,
  output logic [23:0] rgb,
  output logic        underrun,
  output logic        resync_req
`ifdef PIXEL_FETCH_STATS_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam int unsigned NPIX = HDISP * VDISP;
  localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

  localparam logic [1:0] FILL       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] STREAM     = 2'd2;
  localparam logic [1:0] RESYNC     = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] pix_cnt, pix_cnt_nxt;
  logic [23:0]   rgb_nxt;
  logic          streaming;
  logic          err;

  // The frame_start cycle in WAIT_FRAME already behaves as STREAM.
  always_comb begin
    streaming = (state == STREAM) || ((state == WAIT_FRAME) && frame_start);

    if (streaming)
      fifo_rdreq = pix_req & ~fifo_empty;
    else if (state == RESYNC)
      fifo_rdreq = ~fifo_empty;
    else
      fifo_rdreq = 1'b0;

    err = streaming & ((pix_req & fifo_empty) | (frame_start & (pix_cnt != '0)));

    state_nxt = state;
    case (state)
      FILL:       if (fifo_almost_full) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (frame_start) state_nxt = err ? RESYNC : STREAM;
      STREAM:     if (err) state_nxt = RESYNC;
      RESYNC:     if (fifo_empty && frame_start) state_nxt = FILL;
      default:    state_nxt = FILL;
    endcase

    pix_cnt_nxt = pix_cnt;
    if (err)
      pix_cnt_nxt = '0;
    else if (streaming && fifo_rdreq)
      pix_cnt_nxt = (pix_cnt == LAST_PIX) ? '0 : pix_cnt + CW'(1);
    else if (state != STREAM)
      pix_cnt_nxt = '0;

    if (err)
      rgb_nxt = ERR_RGB;
    else if (streaming && fifo_rdreq)
      rgb_nxt = fifo_rdata;
    else if ((state == RESYNC) && pix_req)
      rgb_nxt = ERR_RGB;
    else
      rgb_nxt = '0;
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state      <= FILL;
      pix_cnt    <= '0;
      rgb        <= '0;
      underrun   <= 1'b0;
      resync_req <= 1'b0;
    end else begin
      state      <= state_nxt;
      pix_cnt    <= pix_cnt_nxt;
      rgb        <= rgb_nxt;
      underrun   <= err;
      resync_req <= (state_nxt == RESYNC);
    end
  end

`ifdef PIXEL_FETCH_STATS_EN
  // Counts in step with the registered underrun pulse; saturates at all-ones.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst)
      underrun_count <= '0;
    else if (err && (underrun_count != '1))
      underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch (HDISP=4, VDISP=2) with a queue-based FIFO
// and a behavioural reference model; checks underrun_count when PIXEL_FETCH_STATS_EN is set.
module tb_pixel_fetch;

  localparam int unsigned HD = 4;
  localparam int unsigned VD = 2;
  localparam int unsigned FRAME_PIX = HD * VD;
  localparam logic [23:0] ERR = 24'hFF00FF;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst;
  logic        frame_start;
  logic        pix_req;
  logic [23:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_almost_full;
  logic        fifo_rdreq;
  logic [23:0] rgb;
  logic        underrun;
  logic        resync_req;
`ifdef PIXEL_FETCH_STATS_EN
  logic [15:0] underrun_count;
`endif

  pixel_fetch #(.HDISP(HD), .VDISP(VD)) dut (
    .pixel_clk        (pixel_clk),
    .pixel_rst        (pixel_rst),
    .frame_start      (frame_start),
    .pix_req          (pix_req),
    .fifo_rdata       (fifo_rdata),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_rdreq       (fifo_rdreq),
    .rgb              (rgb),
    .underrun         (underrun),
    .resync_req       (resync_req)
`ifdef PIXEL_FETCH_STATS_EN
    ,
    .underrun_count   (underrun_count)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int failures = 0;

  typedef enum {M_FILL, M_WAIT, M_STREAM, M_RESYNC} mode_t;
  mode_t       mode;
  int          frame_pos;
  int          err_total;
  int          rd_cycles;
  logic [23:0] q[$];
  logic [23:0] exp_rgb;
  logic        exp_under;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mode = M_FILL;
    frame_pos = 0;
    err_total = 0;
  endtask

  task automatic chk_registered();
    chk("rgb", rgb, exp_rgb);
    chk("underrun", {23'd0, underrun}, {23'd0, exp_under});
    chk("resync_req", {23'd0, resync_req}, {23'd0, mode == M_RESYNC});
`ifdef PIXEL_FETCH_STATS_EN
    chk("underrun_count", {8'd0, underrun_count},
        {8'd0, 16'((err_total > 65535) ? 65535 : err_total)});
`endif
  endtask

  // One pixel_clk cycle, entered and left on a falling edge.
  task automatic step(input logic fs, input logic req);
    logic takes, exp_rd, bad, empty;
    frame_start = fs;
    pix_req     = req;
    empty       = (q.size() == 0);
    fifo_empty  = empty;
    fifo_rdata  = empty ? 24'd0 : q[0];
    #1;
    takes  = (mode == M_STREAM) || (mode == M_WAIT && fs);
    exp_rd = takes ? (req && !empty) : (mode == M_RESYNC && !empty);
    chk("fifo_rdreq", {23'd0, fifo_rdreq}, {23'd0, exp_rd});
    if (fifo_rdreq) rd_cycles++;
    bad = takes && ((req && empty) || (fs && frame_pos != 0));
    if (bad) exp_rgb = ERR;
    else if (takes && exp_rd) exp_rgb = q[0];
    else if (mode == M_RESYNC && req) exp_rgb = ERR;
    else exp_rgb = 24'd0;
    exp_under = bad;
    if (bad) begin
      err_total++;
      frame_pos = 0;
      mode = M_RESYNC;
    end else if (takes) begin
      mode = M_STREAM;
      if (exp_rd) frame_pos = (frame_pos + 1) % FRAME_PIX;
    end else if (mode == M_FILL && fifo_almost_full) begin
      mode = M_WAIT;
    end else if (mode == M_RESYNC && empty && fs) begin
      mode = M_FILL;
    end
    if (exp_rd) void'(q.pop_front());
    @(posedge pixel_clk);
    #1;
    chk_registered();
    @(negedge pixel_clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    pixel_rst = 1'b1;
    frame_start = 1'b0;
    pix_req = 1'b0;
    fifo_rdata = 24'd0;
    fifo_empty = 1'b1;
    fifo_almost_full = 1'b0;
    model_reset();
    exp_rgb = 24'd0;
    exp_under = 1'b0;
    repeat (2) @(negedge pixel_clk);
    chk_registered();
    pixel_rst = 1'b0;

    // Fill gating: requests ignored until almost_full, then wait for frame_start.
    for (int i = 1; i <= 8; i++) q.push_back(24'(i));
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    fifo_almost_full = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Normal frame of pixels 1..8 with random blanking gaps.
    rd_cycles = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    idle_steps(2);
    chk("frame_rdreq_cycles", 24'(rd_cycles), 24'd8);

    // Back-to-back frames of random pixels.
    for (int i = 0; i < 16; i++) q.push_back(24'($urandom));
    for (int f = 0; f < 2; f++) begin
      step(1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    end
    idle_steps(1);

    // Underrun after 3 pixels, drain during resync, recover to FILL.
    for (int i = 0; i < 3; i++) q.push_back(24'($urandom));
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    q.push_back(24'h123456);
    q.push_back(24'h654321);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);

    // Misalignment: frame_start after 5 pops.
    fifo_almost_full = 1'b0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) q.push_back(24'($urandom));
    fifo_almost_full = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 12 && q.size() > 0; i++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0);

    // Third error: frame_start straight from WAIT_FRAME with an empty FIFO.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("error_total", 24'(err_total), 24'd3);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      fifo_almost_full = ($urandom_range(0, 3) != 0);
      if (q.size() < 12 && $urandom_range(0, 2) != 0) q.push_back(24'($urandom));
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset in the middle of STREAM.
    pixel_rst = 1'b1;
    #2;
    pixel_rst = 1'b0;
    model_reset();
    q.delete();
    @(negedge pixel_clk);
    for (int i = 0; i < 8; i++) q.push_back(24'($urandom));
    fifo_almost_full = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    #2;
    pixel_rst = 1'b1;
    #1;
    model_reset();
    exp_rgb = 24'd0;
    exp_under = 1'b0;
    chk_registered();
    chk("rdreq_in_reset", {23'd0, fifo_rdreq}, 24'd0);
    @(negedge pixel_clk);
    pixel_rst = 1'b0;
    fifo_almost_full = 1'b0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
